// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back buffer in front of the 32-entry
// register file. Accepts register writes from the load return path and the
// ALU result path, holds them in a DEPTH-entry FIFO and retires one entry per
// cycle onto the register-file write port.
//
// Optional feature: define WB_QUEUE_FORWARD_EN to build the two forwarding
// lookups (youngest pending value per address). Without it the fwd_* outputs
// are tied to zero and the lookup addresses are ignored.
module writeback_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_addr,
    input  logic [N-1:0]             alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_addr,
    input  logic [N-1:0]             mem_data,
    output logic                     mem_ready,
    output logic                     wr_ena,
    output logic [4:0]               wr_addr,
    output logic [N-1:0]             wr_data,
    input  logic [4:0]               fwd_addr0,
    input  logic [4:0]               fwd_addr1,
    output logic                     fwd_hit0,
    output logic                     fwd_hit1,
    output logic [N-1:0]             fwd_data0,
    output logic [N-1:0]             fwd_data1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    addr_q [DEPTH];
    logic [N-1:0]  data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic          nonempty;
    logic [CW-1:0] free;
    logic          mem_push;
    logic          alu_push;
    logic [PW-1:0] alu_slot;
    logic [CW-1:0] cnt_next;

    assign count = cnt;

    // Handshake and push/pop decisions; the head retires every cycle it is
    // occupied, so its slot is counted as free for this cycle's accepts.
    always_comb begin
        nonempty  = (cnt != '0);
        free      = CW'(DEPTH) - cnt + CW'(nonempty);
        mem_ready = (free >= CW'(1));
        alu_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid);
        // Writes to register 0 complete the handshake but are dropped.
        mem_push  = mem_valid && mem_ready && (mem_addr != '0);
        alu_push  = alu_valid && alu_ready && (alu_addr != '0);
        // The load entry is older, so the ALU entry lands behind it.
        alu_slot  = tail + PW'(mem_push);
        cnt_next  = cnt + CW'(mem_push) + CW'(alu_push) - CW'(nonempty);
    end

    // Entry storage: load write first, ALU write in the following slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (mem_push) begin
                addr_q[tail] <= mem_addr;
                data_q[tail] <= mem_data;
            end
            if (alu_push) begin
                addr_q[alu_slot] <= alu_addr;
                data_q[alu_slot] <= alu_data;
            end
        end
    end

    // Head/tail pointers wrap naturally at DEPTH (power of two); occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PW'(nonempty);
            tail <= tail + PW'(mem_push) + PW'(alu_push);
            cnt  <= cnt_next;
        end
    end

    // Register-file write port driven straight from the head entry.
    always_comb begin
        wr_ena  = nonempty;
        wr_addr = '0;
        wr_data = '0;
        if (nonempty) begin
            wr_addr = addr_q[head];
            wr_data = data_q[head];
        end
    end

`ifdef WB_QUEUE_FORWARD_EN
    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit0  = 1'b0;
        fwd_hit1  = 1'b0;
        fwd_data0 = '0;
        fwd_data1 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt) begin
                if ((fwd_addr0 != '0) && (addr_q[head + PW'(i)] == fwd_addr0)) begin
                    fwd_hit0  = 1'b1;
                    fwd_data0 = data_q[head + PW'(i)];
                end
                if ((fwd_addr1 != '0) && (addr_q[head + PW'(i)] == fwd_addr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[head + PW'(i)];
                end
            end
        end
    end
`else
    logic unused_fwd_addr;

    // Forwarding not built: outputs tied off, lookup addresses unused.
    always_comb begin
        fwd_hit0        = 1'b0;
        fwd_hit1        = 1'b0;
        fwd_data0       = '0;
        fwd_data1       = '0;
        unused_fwd_addr = ^{fwd_addr0, fwd_addr1};
    end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: randomized and directed stimulus for writeback_queue,
// checked every cycle against a queue-based model of the pending writes.
module tb_writeback_queue;

    localparam int N     = 32;
    localparam int DEPTH = 4;
`ifdef WB_QUEUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [4:0]    alu_addr, mem_addr;
    logic [N-1:0]  alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          wr_ena;
    logic [4:0]    wr_addr;
    logic [N-1:0]  wr_data;
    logic [4:0]    fwd_addr0, fwd_addr1;
    logic          fwd_hit0, fwd_hit1;
    logic [N-1:0]  fwd_data0, fwd_data1;
    logic [$clog2(DEPTH):0] count;

    writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .fwd_addr0(fwd_addr0), .fwd_addr1(fwd_addr1),
        .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
        .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   addr;
        logic [N-1:0] data;
    } entry_t;

    entry_t       q[$];
    logic [4:0]   dut_log[$];
    int           checks   = 0;
    int           failures = 0;

    // Values sampled from the DUT in the most recent step.
    logic          s_wr_ena, s_alu_ready, s_mem_ready, s_fwd_hit0;
    logic [4:0]    s_wr_addr;
    logic [N-1:0]  s_wr_data, s_fwd_data0;
    logic [31:0]   s_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [N-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (FWD && a != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr == a) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endtask

    // One cycle: drive at negedge, compare everything against the model,
    // then advance the model at the rising edge.
    task automatic step(input logic av, input logic [4:0] aa, input logic [N-1:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [N-1:0] md,
                        input logic [4:0] f0, input logic [4:0] f1);
        int           free;
        logic         e_mr, e_ar, h0, h1;
        logic [N-1:0] d0, d1;
        entry_t       e;
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        fwd_addr0 = f0; fwd_addr1 = f1;
        #1;
        free = DEPTH - q.size() + ((q.size() != 0) ? 1 : 0);
        e_mr = (free >= 1);
        e_ar = (free >= 2) || (free >= 1 && !mv);
        model_fwd(f0, h0, d0);
        model_fwd(f1, h1, d1);
        check("count", 64'(count), 64'(q.size()));
        check("mem_ready", 64'(mem_ready), 64'(e_mr));
        check("alu_ready", 64'(alu_ready), 64'(e_ar));
        check("wr_ena", 64'(wr_ena), 64'(q.size() != 0));
        check("wr_addr", 64'(wr_addr), (q.size() != 0) ? 64'(q[0].addr) : 64'd0);
        check("wr_data", 64'(wr_data), (q.size() != 0) ? 64'(q[0].data) : 64'd0);
        check("fwd_hit0", 64'(fwd_hit0), 64'(h0));
        check("fwd_data0", 64'(fwd_data0), 64'(d0));
        check("fwd_hit1", 64'(fwd_hit1), 64'(h1));
        check("fwd_data1", 64'(fwd_data1), 64'(d1));
        s_wr_ena = wr_ena; s_wr_addr = wr_addr; s_wr_data = wr_data;
        s_alu_ready = alu_ready; s_mem_ready = mem_ready;
        s_fwd_hit0 = fwd_hit0; s_fwd_data0 = fwd_data0; s_count = 32'(count);
        if (wr_ena) dut_log.push_back(wr_addr);
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        if (mv && e_mr && ma != 5'd0) begin e.addr = ma; e.data = md; q.push_back(e); end
        if (av && e_ar && aa != 5'd0) begin e.addr = aa; e.data = ad; q.push_back(e); end
    endtask

    task automatic idle(input logic [4:0] f0);
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, f0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        fwd_addr0 = '0; fwd_addr1 = '0;
        #12;
        check("reset_count", 64'(count), 64'd0);
        check("reset_wr_ena", 64'(wr_ena), 64'd0);
        check("reset_wr_data", 64'(wr_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single ALU push: visible the next cycle, gone the cycle after.
        step(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        idle(5'd0);
        check("lat_wr_ena", 64'(s_wr_ena), 64'd1);
        check("lat_wr_addr", 64'(s_wr_addr), 64'd5);
        check("lat_wr_data", 64'(s_wr_data), 64'hAA);
        idle(5'd0);
        check("lat_after_ena", 64'(s_wr_ena), 64'd0);
        check("lat_after_count", 64'(s_count), 64'd0);

        // Same-cycle mem and ALU to the same register: mem retires first.
        step(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
        idle(5'd3);
        check("order_first", 64'(s_wr_data), 64'h11);
        check("fwd_young_hit", 64'(s_fwd_hit0), 64'(FWD));
        check("fwd_young_data", 64'(s_fwd_data0), FWD ? 64'h22 : 64'd0);
        idle(5'd3);
        check("order_second", 64'(s_wr_data), 64'h22);
        idle(5'd0);

        // Both producers every cycle: queue saturates, ALU gets throttled.
        for (int i = 0; i < 12; i++)
            step(1'b1, 5'((2 * i + 1) % 31 + 1), $urandom, 1'b1, 5'((2 * i) % 31 + 1), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        check("sat_count", 64'(s_count), 64'd4);
        check("sat_alu_ready", 64'(s_alu_ready), 64'd0);
        check("sat_mem_ready", 64'(s_mem_ready), 64'd1);
        for (int i = 0; i < 6; i++) idle(5'($urandom_range(0, 31)));

        // Register 0 write: handshake completes, nothing is queued.
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        check("r0_alu_ready", 64'(s_alu_ready), 64'd1);
        idle(5'd0);
        check("r0_count", 64'(s_count), 64'd0);
        check("r0_wr_ena", 64'(s_wr_ena), 64'd0);
        check("r0_fwd_hit", 64'(s_fwd_hit0), 64'd0);

        // Fill to three entries, then reset in the middle of a cycle.
        step(1'b1, 5'd8, 32'h8, 1'b1, 5'd7, 32'h7, 5'd0, 5'd0);
        step(1'b1, 5'd10, 32'hA, 1'b1, 5'd9, 32'h9, 5'd0, 5'd0);
        @(negedge clk);
        alu_valid = 1'b0; mem_valid = 1'b0;
        #2;
        check("pre_rst_count", 64'(count), 64'd3);
        rst = 1'b0;
        #1;
        check("mid_rst_wr_ena", 64'(wr_ena), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) idle(5'd9);

        // Ten sequential single-producer pushes across pointer wrap.
        dut_log.delete();
        for (int i = 1; i <= 10; i++)
            step(1'b1, 5'(i), 32'(i * 16 + 3), 1'b0, 5'd0, '0, 5'(i), 5'(i - 1));
        for (int i = 0; i < 3; i++) idle(5'd0);
        check("seq_len", 64'(dut_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < dut_log.size(); i++)
            check("seq_order", 64'(dut_log[i]), 64'(i + 1));

        // Random traffic with a small address range to exercise forwarding.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int i = 0; i < 6; i++) idle(5'($urandom_range(0, 7)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
